// File: rtl/btb_pkg.sv
// btb_pkg: shared entry/state types and PC split helpers for btb_assoc.
// BTB_HYSTERESIS_EN adds a per-entry confidence bit to btb_entry_t.
package btb_pkg;

  localparam int BTB_XLEN    = 32;
  localparam int BTB_ENTRIES = 256;
  localparam int BTB_WAYS    = 2;
  localparam int BTB_SETS    = BTB_ENTRIES / BTB_WAYS;
  localparam int BTB_IDX_W   = $clog2(BTB_SETS);
  localparam int BTB_TAG_W   = BTB_XLEN - BTB_IDX_W - 2;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_XLEN-1:0]  target;
    logic                 is_jump;
`ifdef BTB_HYSTERESIS_EN
    logic                 conf;
`endif
  } btb_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } btb_state_e;

  function automatic logic [BTB_IDX_W-1:0] get_idx(
    input logic [BTB_XLEN-1:0] pc
  );
    return BTB_IDX_W'(pc >> 2);
  endfunction

  function automatic logic [BTB_TAG_W-1:0] get_tag(
    input logic [BTB_XLEN-1:0] pc
  );
    return BTB_TAG_W'(pc >> (BTB_IDX_W + 2));
  endfunction

endpackage

// File: rtl/btb_if.sv
// btb_if: fetch lookup, EX update and flush signals of the BTB.
// master = pipeline side, slave = btb_assoc.
interface btb_if #(
  parameter int XLEN = btb_pkg::BTB_XLEN
);
  logic            i_lookup_en;
  logic [XLEN-1:0] i_pc;
  logic            o_hit;
  logic [XLEN-1:0] o_predicted_pc;
  logic            o_is_jump;
  logic            i_valid_update;
  logic [XLEN-1:0] i_upd_pc;
  logic [XLEN-1:0] i_target_pc;
  logic            i_upd_is_jump;
  logic            i_flush;
  logic            o_flush_busy;

  modport master (
    output i_lookup_en, i_pc,
    output i_valid_update, i_upd_pc,
    output i_target_pc, i_upd_is_jump,
    output i_flush,
    input  o_hit, o_predicted_pc,
    input  o_is_jump, o_flush_busy
  );

  modport slave (
    input  i_lookup_en, i_pc,
    input  i_valid_update, i_upd_pc,
    input  i_target_pc, i_upd_is_jump,
    input  i_flush,
    output o_hit, o_predicted_pc,
    output o_is_jump, o_flush_busy
  );
endinterface

// File: rtl/btb_victim_sel.sv
// btb_victim_sel: picks the way to allocate in a set.
// Lowest invalid way first; round-robin pointer once the set is full.
module btb_victim_sel #(
  parameter int WAYS = 2,
  parameter int WW   = 1
) (
  input  logic [WAYS-1:0] valid,
  input  logic [WW-1:0]   rr_ptr,
  output logic [WW-1:0]   way,
  output logic            adv
);

  always_comb begin
    way = rr_ptr;
    adv = &valid;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) way = WW'(w);
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// btb_assoc: N-way set-associative BTB, round-robin fill, flush sequencer.
// Define BTB_HYSTERESIS_EN for two-strike target retraining.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int XLEN    = BTB_XLEN,
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int WAYS    = BTB_WAYS
) (
  input logic  i_clk,
  input logic  i_rst_n,
  btb_if.slave bus
);

  localparam int SETS  = ENTRIES / WAYS;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;

  btb_entry_t       mem_q [SETS][WAYS];
  logic [WW-1:0]    rr_q  [SETS];
  btb_state_e       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             busy;

  assign busy = (state_q == FLUSH);
  assign bus.o_flush_busy = busy;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [XLEN-1:0]  lk_tgt;
  logic             lk_jmp;

  always_comb begin
    lk_idx = get_idx(bus.i_pc);
    lk_tag = get_tag(bus.i_pc);
    lk_hit = 1'b0;
    lk_tgt = '0;
    lk_jmp = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (mem_q[lk_idx][w].valid &&
          mem_q[lk_idx][w].tag == lk_tag) begin
        lk_hit = 1'b1;
        lk_tgt = mem_q[lk_idx][w].target;
        lk_jmp = mem_q[lk_idx][w].is_jump;
      end
    end
    if (!bus.i_lookup_en || busy) begin
      lk_hit = 1'b0;
      lk_tgt = '0;
      lk_jmp = 1'b0;
    end
  end

  assign bus.o_hit          = lk_hit;
  assign bus.o_predicted_pc = lk_tgt;
  assign bus.o_is_jump      = lk_jmp;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic [WAYS-1:0]  up_vld;
  logic             up_match;
  logic [WW-1:0]    up_mway;

  always_comb begin
    up_idx   = get_idx(bus.i_upd_pc);
    up_tag   = get_tag(bus.i_upd_pc);
    up_vld   = '0;
    up_match = 1'b0;
    up_mway  = '0;
    for (int w = 0; w < WAYS; w++) begin
      up_vld[w] = mem_q[up_idx][w].valid;
      if (up_vld[w] &&
          mem_q[up_idx][w].tag == up_tag) begin
        up_match = 1'b1;
        up_mway  = WW'(w);
      end
    end
  end

  logic [WW-1:0] vic_way;
  logic          vic_adv;

  btb_victim_sel #(
    .WAYS (WAYS),
    .WW   (WW)
  ) u_vsel (
    .valid  (up_vld),
    .rr_ptr (rr_q[up_idx]),
    .way    (vic_way),
    .adv    (vic_adv)
  );

  logic          wr_en;
  logic [WW-1:0] wr_way;
  logic          rr_adv;
  logic [WW-1:0] rr_nxt;
  btb_entry_t    wr_ent;

  always_comb begin
    wr_en  = bus.i_valid_update &&
             (state_q == IDLE) &&
             !bus.i_flush;
    wr_way = up_match ? up_mway : vic_way;
    rr_adv = wr_en && !up_match && vic_adv;
    rr_nxt = (rr_q[up_idx] == WW'(WAYS - 1))
           ? '0 : rr_q[up_idx] + 1'b1;
    wr_ent         = '0;
    wr_ent.valid   = 1'b1;
    wr_ent.tag     = up_tag;
    wr_ent.target  = bus.i_target_pc;
    wr_ent.is_jump = bus.i_upd_is_jump;
`ifdef BTB_HYSTERESIS_EN
    wr_ent.conf = 1'b1;
    // first mismatch on a confident entry only drops confidence
    if (up_match &&
        mem_q[up_idx][up_mway].target != bus.i_target_pc &&
        mem_q[up_idx][up_mway].conf) begin
      wr_ent.target = mem_q[up_idx][up_mway].target;
      wr_ent.conf   = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_flush) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(SETS - 1)) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          mem_q[s][w].valid <= 1'b0;
`ifdef BTB_HYSTERESIS_EN
          mem_q[s][w].conf  <= 1'b0;
`endif
        end
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (busy) begin
        rr_q[cnt_q] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          mem_q[cnt_q][w].valid <= 1'b0;
        end
      end else if (wr_en) begin
        mem_q[up_idx][wr_way] <= wr_ent;
        if (rr_adv) rr_q[up_idx] <= rr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: directed scoreboard bench for btb_assoc.
// Expected lookups are queued by stimulus and checked by a negedge monitor.
module tb_btb_assoc;
  import btb_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btb_if #(.XLEN(32)) bus ();

  btb_assoc #(
    .XLEN    (32),
    .ENTRIES (256),
    .WAYS    (2)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic        h;
    logic [31:0] t;
    logic        j;
  } exp_t;

  exp_t  expq[$];
  string nmq[$];
  exp_t  m_e;
  string m_nm;
  logic  mon_v = 1'b0;
  int    n_chk = 0;
  int    n_fail = 0;
  int    busy_cnt;
  logic  done;

  always @(negedge clk) begin
    if (mon_v) begin
      n_chk++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: no expected entry");
      end else begin
        m_e  = expq.pop_front();
        m_nm = nmq.pop_front();
        if (bus.o_hit !== m_e.h ||
            bus.o_predicted_pc !== m_e.t ||
            bus.o_is_jump !== m_e.j) begin
          n_fail++;
          $display("FAIL %s: got hit=%0b pc=0x%0h jmp=%0b, expected hit=%0b pc=0x%0h jmp=%0b",
                   m_nm, bus.o_hit, bus.o_predicted_pc, bus.o_is_jump,
                   m_e.h, m_e.t, m_e.j);
        end
      end
    end
  end

  task automatic drive(input logic le, input logic [31:0] pc,
                       input logic uv, input logic [31:0] upc,
                       input logic [31:0] tgt, input logic uj,
                       input logic fl);
    @(posedge clk);
    #1;
    mon_v              = 1'b0;
    bus.i_lookup_en    = le;
    bus.i_pc           = pc;
    bus.i_valid_update = uv;
    bus.i_upd_pc       = upc;
    bus.i_target_pc    = tgt;
    bus.i_upd_is_jump  = uj;
    bus.i_flush        = fl;
  endtask

  task automatic exp_push(input string nm, input logic h,
                          input logic [31:0] t, input logic j);
    exp_t e;
    e.h = h;
    e.t = t;
    e.j = j;
    expq.push_back(e);
    nmq.push_back(nm);
    mon_v = 1'b1;
  endtask

  task automatic lk(input string nm, input logic le, input logic [31:0] pc,
                    input logic h, input logic [31:0] t, input logic j);
    drive(le, pc, 1'b0, '0, '0, 1'b0, 1'b0);
    exp_push(nm, h, t, j);
  endtask

  task automatic upd(input logic [31:0] upc, input logic [31:0] tgt,
                     input logic uj);
    drive(1'b0, '0, 1'b1, upc, tgt, uj, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  initial begin
    bus.i_lookup_en    = 1'b0;
    bus.i_pc           = '0;
    bus.i_valid_update = 1'b0;
    bus.i_upd_pc       = '0;
    bus.i_target_pc    = '0;
    bus.i_upd_is_jump  = 1'b0;
    bus.i_flush        = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    chk("reset_flush_busy", 32'(bus.o_flush_busy), 32'h0);
    lk("reset_lookup", 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);

    // update and lookup of the same PC in one cycle: no bypass
    drive(1'b1, 32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0);
    exp_push("same_cycle_miss", 1'b0, 32'h0, 1'b0);
    lk("next_cycle_hit", 1'b1, 32'h100, 1'b1, 32'h200, 1'b1);

    upd(32'h300, 32'h340, 1'b0);
    upd(32'h500, 32'h540, 1'b0);
    lk("evicted_0x100", 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    lk("way1_0x300", 1'b1, 32'h300, 1'b1, 32'h340, 1'b0);
    lk("way0_0x500", 1'b1, 32'h500, 1'b1, 32'h540, 1'b0);
    lk("pc_low_bits", 1'b1, 32'h502, 1'b1, 32'h540, 1'b0);
    lk("lookup_disabled", 1'b0, 32'h500, 1'b0, 32'h0, 1'b0);

    upd(32'h300, 32'h400, 1'b0);
`ifdef BTB_HYSTERESIS_EN
    lk("retrain_first", 1'b1, 32'h300, 1'b1, 32'h340, 1'b0);
`else
    lk("retrain_first", 1'b1, 32'h300, 1'b1, 32'h400, 1'b0);
`endif
    lk("no_dup_0x500", 1'b1, 32'h500, 1'b1, 32'h540, 1'b0);
    upd(32'h300, 32'h400, 1'b0);
    lk("retrain_second", 1'b1, 32'h300, 1'b1, 32'h400, 1'b0);

    // set full, pointer now at way 1 -> 0x300 is the victim
    upd(32'h700, 32'h740, 1'b1);
    lk("rr_evict_0x300", 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
    lk("rr_keep_0x500", 1'b1, 32'h500, 1'b1, 32'h540, 1'b0);
    lk("rr_new_0x700", 1'b1, 32'h700, 1'b1, 32'h740, 1'b1);

    upd(32'h1000, 32'h2000, 1'b0);
    upd(32'h1FC, 32'h3000, 1'b1);
    lk("set0_hit", 1'b1, 32'h1000, 1'b1, 32'h2000, 1'b0);
    lk("set127_hit", 1'b1, 32'h1FC, 1'b1, 32'h3000, 1'b1);

    // flush pulse with a colliding update that must be dropped
    drive(1'b0, '0, 1'b1, 32'h900, 32'h990, 1'b0, 1'b1);
    busy_cnt = 0;
    done     = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (i == 10) begin
        drive(1'b1, 32'h500, 1'b0, '0, '0, 1'b0, 1'b0);
        exp_push("lookup_while_busy", 1'b0, 32'h0, 1'b0);
      end else if (i == 20) begin
        drive(1'b0, '0, 1'b1, 32'hA00, 32'hAA0, 1'b0, 1'b0);
      end else if (i == 30) begin
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
      end else begin
        idle();
      end
      @(negedge clk);
      if (bus.o_flush_busy) busy_cnt++;
      else if (busy_cnt > 0) done = 1'b1;
    end
    chk("flush_busy_cycles", 32'(busy_cnt), 32'd128);

    lk("post_flush_0x500", 1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
    lk("post_flush_0x700", 1'b1, 32'h700, 1'b0, 32'h0, 1'b0);
    lk("post_flush_0x1000", 1'b1, 32'h1000, 1'b0, 32'h0, 1'b0);
    lk("post_flush_0x1FC", 1'b1, 32'h1FC, 1'b0, 32'h0, 1'b0);
    lk("flush_cycle_upd_dropped", 1'b1, 32'h900, 1'b0, 32'h0, 1'b0);
    lk("busy_upd_dropped", 1'b1, 32'hA00, 1'b0, 32'h0, 1'b0);
    upd(32'h900, 32'h990, 1'b0);
    lk("post_flush_alloc", 1'b1, 32'h900, 1'b1, 32'h990, 1'b0);

    // reset in the middle of a flush, before set 0x40 is reached
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) idle();
    chk("busy_at_cycle_50", 32'(bus.o_flush_busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_busy", 32'(bus.o_flush_busy), 32'h0);
    #2;
    rst_n = 1'b1;
    lk("reset_clears_valid", 1'b1, 32'h900, 1'b0, 32'h0, 1'b0);
    idle();
    @(negedge clk);
    chk("idle_after_reset", 32'(bus.o_flush_busy), 32'h0);
    chk("scoreboard_drained", 32'(expq.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
